// File: rtl/key_pad_pkg.sv
// rtl/key_pad_pkg.sv - shared keypad types and helpers
// Purpose: definitions shared by the keypad scanner and the keypad emulator.
//   T1MS_DEFAULT  : clk cycles per 1 ms tick at 50 MHz
//   key_code_t    : 4-bit key code {row_idx[1:0], col_idx[1:0]}
//   key_onehot_t  : one-hot row and column lines of a key
//   emu_state_t   : emulator FSM states
//   key_to_onehot : key code -> {row_bit, col_bit}
package key_pad_pkg;

  localparam int T1MS_DEFAULT = 50_000;

  typedef logic [3:0] key_code_t;

  typedef struct packed {
    logic [3:0] row_bit;
    logic [3:0] col_bit;
  } key_onehot_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_BNC,
    ST_HOLD,
    ST_REL_BNC,
    ST_GAP
  } emu_state_t;

  function automatic key_onehot_t key_to_onehot(input key_code_t key);
    key_onehot_t r;
    r.row_bit = 4'b0001 << key[3:2];
    r.col_bit = 4'b0001 << key[1:0];
    return r;
  endfunction

endpackage

// File: rtl/key_pad_emu_if.sv
// rtl/key_pad_emu_if.sv - key-press command and status interface
// Purpose: groups the command handshake and status lines of the keypad emulator.
//   cmd_valid   : key-press command valid (master -> slave)
//   cmd_ready   : emulator can take a command (slave -> master)
//   cmd_key     : key code to press
//   cmd_hold_ms : stable-closed time in ms ticks, 0 behaves as 1
//   cmd_abort   : force immediate release
//   busy        : emulator is not idle
//   done        : one-cycle pulse when a press sequence completes
// Modports: master drives commands, slave is the emulator.
interface key_pad_emu_if;
  import key_pad_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  key_code_t   cmd_key;
  logic [15:0] cmd_hold_ms;
  logic        cmd_abort;
  logic        busy;
  logic        done;

  modport master (
    output cmd_valid, cmd_key, cmd_hold_ms, cmd_abort,
    input  cmd_ready, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_key, cmd_hold_ms, cmd_abort,
    output cmd_ready, busy, done
  );

endinterface

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - free-running millisecond tick generator
// Purpose: counts 0..T1MS-1 and flags the last count as the 1 ms tick.
//   clk   in  : system clock
//   rst_n in  : synchronous active-low reset, clears the counter
//   tick  out : high for the one cycle where the count equals T1MS-1
module ms_tick_gen #(
  parameter int T1MS = key_pad_pkg::T1MS_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (T1MS > 1) ? $clog2(T1MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(T1MS - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/key_pad_emu.sv
// rtl/key_pad_emu.sv - 4x4 matrix keypad emulator with contact bounce
// Purpose: far end of a keypad scan interface; answers the scanner's column
//   drive with row feedback as if the commanded key were pressed, including
//   bounce on press and release and an open-contact gap afterwards.
//   clk    in  : system clock
//   rst_n  in  : synchronous active-low reset
//   col    in  : column drive from scanner, active-high
//   row    out : row feedback to scanner, active-high, combinational from col
//   cmd_if     : key_pad_emu_if.slave (command handshake, abort, busy, done)
module key_pad_emu
  import key_pad_pkg::*;
#(
  parameter int T1MS      = T1MS_DEFAULT,
  parameter int BOUNCE_MS = 4,
  parameter int GAP_MS    = 25
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    col,
  output logic [3:0]    row,
  key_pad_emu_if.slave  cmd_if
);

  localparam logic [15:0] BNC_LAST = 16'(BOUNCE_MS - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_MS - 1);

  emu_state_t  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] hold_q, hold_d;
  key_code_t   key_q, key_d;
  logic        contact_q, contact_d;
  logic        done_q, done_d;
  logic        tick;
  logic        gap_exit;
  key_onehot_t key_oh;

  ms_tick_gen #(.T1MS(T1MS)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hold_q    <= 16'd1;
      key_q     <= '0;
      contact_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      key_q     <= key_d;
      contact_q <= contact_d;
      done_q    <= done_d;
    end
  end

  // The GAP exit on its final tick wins over a simultaneous abort.
  assign gap_exit = (state_q == ST_GAP) && tick && (cnt_q == GAP_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    key_d     = key_q;
    contact_d = contact_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        contact_d = 1'b0;
        if (cmd_if.cmd_valid) begin
          key_d     = cmd_if.cmd_key;
          hold_d    = (cmd_if.cmd_hold_ms == 16'd0) ? 16'd1 : cmd_if.cmd_hold_ms;
          cnt_d     = '0;
          contact_d = 1'b1;
          state_d   = (BOUNCE_MS > 0) ? ST_PRESS_BNC : ST_HOLD;
        end
      end
      ST_PRESS_BNC: begin
        if (tick) begin
          if (cnt_q == BNC_LAST) begin
            state_d   = ST_HOLD;
            cnt_d     = '0;
            contact_d = 1'b1;
          end else begin
            cnt_d     = cnt_q + 16'd1;
            contact_d = ~contact_q;
          end
        end
      end
      ST_HOLD: begin
        contact_d = 1'b1;
        if (tick) begin
          // hold_q is at least 1, so hold_q-1 never wraps.
          if (cnt_q == hold_q - 16'd1) begin
            state_d   = (BOUNCE_MS > 0) ? ST_REL_BNC : ST_GAP;
            cnt_d     = '0;
            contact_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      ST_REL_BNC: begin
        if (tick) begin
          if (cnt_q == BNC_LAST) begin
            state_d   = ST_GAP;
            cnt_d     = '0;
            contact_d = 1'b0;
          end else begin
            cnt_d     = cnt_q + 16'd1;
            contact_d = ~contact_q;
          end
        end
      end
      ST_GAP: begin
        contact_d = 1'b0;
        if (tick) begin
          if (gap_exit) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        contact_d = 1'b0;
      end
    endcase

    if (cmd_if.cmd_abort && (state_q != ST_IDLE) && !gap_exit) begin
      state_d   = ST_GAP;
      cnt_d     = '0;
      contact_d = 1'b0;
      done_d    = 1'b0;
    end
  end

  assign key_oh = key_to_onehot(key_q);

  // Zero latency from col to row; an all-ones column probe also hits the key.
  assign row = (contact_q && |(col & key_oh.col_bit)) ? key_oh.row_bit : 4'b0000;

  assign cmd_if.cmd_ready = (state_q == ST_IDLE);
  assign cmd_if.busy      = (state_q != ST_IDLE);
  assign cmd_if.done      = done_q;

endmodule

// File: tb/tb_key_pad_emu.sv
// tb/tb_key_pad_emu.sv - directed self-checking bench for key_pad_emu
module tb_key_pad_emu;

  logic       clk;
  logic       rst_n;
  logic [3:0] col, col0;
  logic [3:0] row, row0;
  int         cyc;
  int         done_cnt, done0_cnt;
  int         checks, errors;

  key_pad_emu_if emu_if ();
  key_pad_emu_if emu0_if ();

  key_pad_emu #(.T1MS(10), .BOUNCE_MS(2), .GAP_MS(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .col    (col),
    .row    (row),
    .cmd_if (emu_if.slave)
  );

  key_pad_emu #(.T1MS(10), .BOUNCE_MS(0), .GAP_MS(3)) dut0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .col    (col0),
    .row    (row0),
    .cmd_if (emu0_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side cycle count since reset release; ticks land on multiples of 10.
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (emu_if.done === 1'b1)  done_cnt  <= done_cnt + 1;
    if (emu0_if.done === 1'b1) done0_cnt <= done0_cnt + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int k);
    int guard;
    guard = 0;
    while (cyc < k) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 5000) begin
        $display("FAIL goto_timeout observed %0d expected %0d", cyc, k);
        $fatal(1, "cycle wait expired");
      end
    end
  endtask

  task automatic set_col(input logic [3:0] c);
    col = c;
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; done_cnt = 0; done0_cnt = 0; cyc = 0;
    rst_n = 1'b0;
    col = 4'b0001; col0 = 4'b1000;
    emu_if.cmd_valid = 1'b0; emu_if.cmd_key = '0; emu_if.cmd_hold_ms = '0; emu_if.cmd_abort = 1'b0;
    emu0_if.cmd_valid = 1'b0; emu0_if.cmd_key = '0; emu0_if.cmd_hold_ms = '0; emu0_if.cmd_abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst_row", 16'(row), 16'h0);
    chk("rst_ready", 16'(emu_if.cmd_ready), 16'h1);
    chk("rst_busy", 16'(emu_if.busy), 16'h0);
    chk("rst_done", 16'(emu_if.done), 16'h0);
    rst_n = 1'b1;

    // Key 6, hold 5: row bit 1 answers column 2
    goto(3);
    emu_if.cmd_valid = 1'b1; emu_if.cmd_key = 4'h6; emu_if.cmd_hold_ms = 16'd5;
    goto(4);
    emu_if.cmd_valid = 1'b0;
    chk("k6_ready", 16'(emu_if.cmd_ready), 16'h0);
    chk("k6_busy", 16'(emu_if.busy), 16'h1);
    set_col(4'b0100); chk("k6_press_col2", 16'(row), 16'h2);
    set_col(4'b0001); chk("k6_press_col0", 16'(row), 16'h0);
    set_col(4'b0010); chk("k6_press_col1", 16'(row), 16'h0);
    set_col(4'b1000); chk("k6_press_col3", 16'(row), 16'h0);
    set_col(4'b1111); chk("k6_any_probe", 16'(row), 16'h2);
    set_col(4'b0100);
    goto(10); chk("k6_bounce_open", 16'(row), 16'h0);
    goto(20); chk("k6_hold_start", 16'(row), 16'h2);
    goto(69); chk("k6_hold_end", 16'(row), 16'h2);
    goto(70); chk("k6_rel_open", 16'(row), 16'h0);
    goto(80); chk("k6_rel_bounce", 16'(row), 16'h2);
    goto(90); chk("k6_gap_open", 16'(row), 16'h0);
    goto(119); chk("k6_pre_done", 16'(emu_if.done), 16'h0);
    chk("k6_pre_busy", 16'(emu_if.busy), 16'h1);
    goto(120); chk("k6_done", 16'(emu_if.done), 16'h1);
    chk("k6_idle_ready", 16'(emu_if.cmd_ready), 16'h1);
    goto(121); chk("k6_done_width", 16'(emu_if.done), 16'h0);
    chk("k6_done_count", 16'(done_cnt), 16'd1);

    // Key 3 aborted during HOLD; a second command while busy is dropped
    goto(123);
    emu_if.cmd_valid = 1'b1; emu_if.cmd_key = 4'h3; emu_if.cmd_hold_ms = 16'd10;
    goto(124);
    emu_if.cmd_valid = 1'b0;
    set_col(4'b1000);
    goto(140); chk("k3_hold", 16'(row), 16'h1);
    goto(145);
    emu_if.cmd_abort = 1'b1;
    emu_if.cmd_valid = 1'b1; emu_if.cmd_key = 4'h5; emu_if.cmd_hold_ms = 16'd1;
    goto(146);
    emu_if.cmd_abort = 1'b0;
    chk("k3_abort_row", 16'(row), 16'h0);
    chk("k3_abort_busy", 16'(emu_if.busy), 16'h1);
    goto(160);
    emu_if.cmd_valid = 1'b0;
    goto(169); chk("k3_pre_done", 16'(emu_if.done), 16'h0);
    goto(170); chk("k3_done", 16'(emu_if.done), 16'h1);
    goto(171); chk("k3_idle", 16'(emu_if.busy), 16'h0);
    goto(172);
    emu_if.cmd_abort = 1'b1;
    goto(173);
    emu_if.cmd_abort = 1'b0;
    chk("idle_abort_busy", 16'(emu_if.busy), 16'h0);

    // BOUNCE_MS=0 build: key F, hold 0 acts as one tick of clean contact
    goto(180);
    emu0_if.cmd_valid = 1'b1; emu0_if.cmd_key = 4'hF; emu0_if.cmd_hold_ms = 16'd0;
    goto(181);
    emu0_if.cmd_valid = 1'b0;
    chk("kf_row", 16'(row0), 16'h8);
    chk("kf_busy", 16'(emu0_if.busy), 16'h1);
    goto(189); chk("kf_row_last", 16'(row0), 16'h8);
    goto(190); chk("kf_release", 16'(row0), 16'h0);
    goto(219); chk("kf_pre_done", 16'(emu0_if.done), 16'h0);
    goto(220); chk("kf_done", 16'(emu0_if.done), 16'h1);

    // No extra done from the dropped command
    goto(260); chk("drop_done_count", 16'(done_cnt), 16'd2);

    // Reset during HOLD of key 9
    goto(301);
    emu_if.cmd_valid = 1'b1; emu_if.cmd_key = 4'h9; emu_if.cmd_hold_ms = 16'd20;
    goto(302);
    emu_if.cmd_valid = 1'b0;
    goto(325);
    set_col(4'b0010); chk("k9_hold", 16'(row), 16'h4);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("k9_rst_row", 16'(row), 16'h0);
    chk("k9_rst_ready", 16'(emu_if.cmd_ready), 16'h1);
    chk("k9_rst_busy", 16'(emu_if.busy), 16'h0);
    rst_n = 1'b1;
    goto(300);
    chk("k9_no_done", 16'(done_cnt), 16'd2);
    chk("kf_done_count", 16'(done0_cnt), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
